// File: rtl/mm_axis_reader.sv
// Memory-to-stream reader: fetches a byte-length region with INCR bursts that
// never cross a 4 KB page and emits it as one AXI4-Stream frame.
module mm_axis_reader #(
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH    = 34,
  parameter int unsigned LEN_WIDTH     = 20,
  parameter int unsigned ID_WIDTH      = 6,
  parameter int unsigned MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic                  done,
  output logic                  done_err,
  output logic                  busy,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int unsigned ByteShift = $clog2(KEEP_WIDTH);
  // Beat counters must hold ceil(max_len / BYTES), one bit more than len >> shift.
  localparam int unsigned BeatW     = LEN_WIDTH - ByteShift + 1;
  localparam int unsigned CntW      = (BeatW > 13) ? BeatW : 13;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BeatW-1:0]        ar_rem_q;     // beats not yet requested
  logic [BeatW-1:0]        rx_rem_q;     // beats not yet received
  logic [KEEP_WIDTH-1:0]   last_keep_q;
  logic                    err_q;
  logic                    tvalid_q, tlast_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic [KEEP_WIDTH-1:0]   tkeep_q;

  logic                    cmd_acc, ar_hs, r_hs, t_hs, final_beat;
  logic [LEN_WIDTH:0]      len_round;
  logic [BeatW-1:0]        cmd_beats;
  logic [KEEP_WIDTH-1:0]   cmd_keep;
  logic [ByteShift-1:0]    len_tail;
  logic [12:0]             page_bytes;
  logic [CntW-1:0]         page_beats, burst;
  logic                    unused_rid;

  assign unused_rid = ^m_axi_rid;

  assign cmd_acc    = cmd_valid && cmd_ready;
  assign ar_hs      = m_axi_arvalid && m_axi_arready;
  assign r_hs       = m_axi_rvalid && m_axi_rready;
  assign t_hs       = tvalid_q && m_axis_tready;
  assign final_beat = (rx_rem_q == BeatW'(1));

  assign len_round  = {1'b0, cmd_len} + (LEN_WIDTH + 1)'(KEEP_WIDTH - 1);
  assign cmd_beats  = BeatW'(len_round >> ByteShift);
  assign len_tail   = cmd_len[ByteShift-1:0];
  assign page_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
  assign page_beats = CntW'(page_bytes >> ByteShift);

  // Byte-enable mask for the final beat of a command.
  always_comb begin
    cmd_keep = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      cmd_keep[i] = (len_tail == '0) || (i < int'(len_tail));
    end
  end

  // Burst size: smallest of remaining beats, burst limit and beats left in the page.
  always_comb begin
    burst = CntW'(ar_rem_q);
    if (CntW'(MAX_BURST_LEN) < burst) burst = CntW'(MAX_BURST_LEN);
    if (page_beats < burst) burst = page_beats;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_acc) state_d = (cmd_len == '0) ? StDone : StAddr;
      StAddr:  if (ar_hs) state_d = StData;
      StData:  if (r_hs && m_axi_rlast) state_d = (ar_rem_q != '0) ? StAddr : StDrain;
      StDrain: if (t_hs && tlast_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Command bookkeeping: address, beat counters, tail mask, sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      ar_rem_q    <= '0;
      rx_rem_q    <= '0;
      last_keep_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (cmd_acc) begin
        addr_q      <= cmd_addr;
        ar_rem_q    <= cmd_beats;
        rx_rem_q    <= cmd_beats;
        last_keep_q <= cmd_keep;
      end
      if (ar_hs) begin
        addr_q   <= addr_q + (ADDR_WIDTH'(burst) << ByteShift);
        ar_rem_q <= ar_rem_q - BeatW'(burst);
      end
      if (r_hs) begin
        rx_rem_q <= rx_rem_q - BeatW'(1);
        if (m_axi_rresp != 2'b00) err_q <= 1'b1;
      end
      if (state_q == StDone) err_q <= 1'b0;
    end
  end

  // Single-entry stream output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
    end else if (r_hs) begin
      tvalid_q <= 1'b1;
      tdata_q  <= m_axi_rdata;
      tkeep_q  <= final_beat ? last_keep_q : '1;
      tlast_q  <= final_beat;
    end else if (t_hs) begin
      tvalid_q <= 1'b0;
    end
  end

  assign cmd_ready     = (state_q == StIdle) && rst_n;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign done_err      = done && err_q;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = (state_q == StAddr) ? 8'(burst - CntW'(1)) : 8'd0;
  assign m_axi_arsize  = 3'(ByteShift);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = (state_q == StAddr);
  assign m_axi_rready  = (state_q == StData) && (!tvalid_q || m_axis_tready);

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_mm_axis_reader.sv
// Bench for mm_axis_reader: AXI memory responder, frame/burst model, per-cycle checker.
module tb_mm_axis_reader;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int AW = 34;
  localparam int LW = 20;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid, cmd_ready, done, done_err, busy;
  logic [IW-1:0] m_axi_arid, m_axi_rid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize, m_axi_arprot;
  logic [1:0]    m_axi_arburst, m_axi_rresp;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;

  mm_axis_reader dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .done(done), .done_err(done_err), .busy(busy),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic last; } rbeat_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } tbeat_t;

  rbeat_t slave_q[$];
  ar_t    exp_ar[$];
  tbeat_t exp_bt[$];

  int vectors = 0, miscompares = 0;
  int acc_cyc = -10, tlast_cyc = -10, rlast_cyc = -10;
  int done_cnt = 0, ar_seen = 0, beats_seen = 0;
  bit stall = 0, err_en = 0, exp_err_g = 0, len0_g = 0;
  logic [AW-1:0] cmd_addr_g = '0, err_addr_g = '0;
  bit prev_done = 0, prev_stall = 0, r_hs_s = 0;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;

  // Memory contents: each 32-bit word derived from its own byte address.
  function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = (a[31:0] + 32'(k * 4)) ^ 32'h9E37_5A00;
    return d;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder plus per-cycle compare against the expected queues.
  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0;
    m_axi_rlast = 0; m_axi_rid = '0; m_axis_tready = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axis_tready = 0;
      end else begin
        m_axi_arready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_axis_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!(m_axi_rvalid && !r_hs_s)) begin
          if (slave_q.size() > 0 && (!stall || $urandom_range(0, 2) != 0)) begin
            m_axi_rvalid = 1;
            m_axi_rdata  = mkdata(slave_q[0].addr);
            m_axi_rlast  = slave_q[0].last;
            m_axi_rresp  = (err_en && slave_q[0].addr == err_addr_g) ? 2'b10 : 2'b00;
          end else begin
            m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
          end
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        slave_q.delete(); exp_ar.delete(); exp_bt.delete();
        prev_stall = 0; prev_done = 0; r_hs_s = 0;
      end else begin
        if (prev_stall) begin
          chk("tvalid held", DW'(m_axis_tvalid), DW'(1));
          chk("tdata held", m_axis_tdata, prev_data);
          chk("tkeep held", DW'(m_axis_tkeep), DW'(prev_keep));
          chk("tlast held", DW'(m_axis_tlast), DW'(prev_last));
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata; prev_keep = m_axis_tkeep; prev_last = m_axis_tlast;
        if (prev_done) chk("cmd_ready after done", DW'(cmd_ready), DW'(1));
        prev_done = done;
        if (cyc == rlast_cyc + 1 && exp_ar.size() > 0)
          chk("arvalid after rlast", DW'(m_axi_arvalid), DW'(1));
        if (cyc == acc_cyc + 1) begin
          if (len0_g) chk("len0 no arvalid", DW'(m_axi_arvalid), DW'(0));
          else begin
            chk("arvalid after accept", DW'(m_axi_arvalid), DW'(1));
            chk("araddr after accept", DW'(m_axi_araddr), DW'(cmd_addr_g));
          end
        end
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (m_axi_arvalid && m_axi_arready) begin
          ar_seen++;
          if (exp_ar.size() == 0) chk("unexpected AR", DW'(1), DW'(0));
          else begin
            chk("araddr", DW'(m_axi_araddr), DW'(exp_ar[0].addr));
            chk("arlen", DW'(m_axi_arlen), DW'(exp_ar[0].len));
            void'(exp_ar.pop_front());
          end
          chk("arsize", DW'(m_axi_arsize), DW'(6));
          chk("arburst", DW'(m_axi_arburst), DW'(1));
          for (int k = 0; k <= int'(m_axi_arlen); k++)
            slave_q.push_back('{addr: m_axi_araddr + AW'(k * 64), last: (k == int'(m_axi_arlen))});
        end
        r_hs_s = m_axi_rvalid && m_axi_rready;
        if (r_hs_s && slave_q.size() > 0) begin
          if (slave_q[0].last) rlast_cyc = cyc;
          void'(slave_q.pop_front());
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beats_seen++;
          if (exp_bt.size() == 0) chk("unexpected beat", DW'(1), DW'(0));
          else begin
            chk("tdata", m_axis_tdata, exp_bt[0].data);
            chk("tkeep", DW'(m_axis_tkeep), DW'(exp_bt[0].keep));
            chk("tlast", DW'(m_axis_tlast), DW'(exp_bt[0].last));
            void'(exp_bt.pop_front());
          end
          if (m_axis_tlast) tlast_cyc = cyc;
        end
        if (done) begin
          chk("done_err", DW'(done_err), DW'(exp_err_g));
          chk("busy with done", DW'(busy), DW'(1));
          if (len0_g) chk("done timing len0", DW'(cyc), DW'(acc_cyc + 1));
          else        chk("done timing", DW'(cyc), DW'(tlast_cyc + 1));
          done_cnt++;
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, " cmd_ready"}, DW'(cmd_ready), DW'(0));
    chk({tag, " arvalid"}, DW'(m_axi_arvalid), DW'(0));
    chk({tag, " rready"}, DW'(m_axi_rready), DW'(0));
    chk({tag, " tvalid"}, DW'(m_axis_tvalid), DW'(0));
    chk({tag, " tlast"}, DW'(m_axis_tlast), DW'(0));
    chk({tag, " tkeep"}, DW'(m_axis_tkeep), DW'(0));
    chk({tag, " tdata"}, m_axis_tdata, DW'(0));
    chk({tag, " done"}, DW'(done), DW'(0));
    chk({tag, " done_err"}, DW'(done_err), DW'(0));
    chk({tag, " busy"}, DW'(busy), DW'(0));
    chk({tag, " araddr"}, DW'(m_axi_araddr), DW'(0));
    chk({tag, " arlen"}, DW'(m_axi_arlen), DW'(0));
  endtask

  // Builds the expected frame and burst list from the address/length rules.
  task automatic build_model(input logic [AW-1:0] addr, input int len);
    int beats, cnt, nb;
    logic [AW-1:0] a, s;
    tbeat_t t;
    beats = (len + 63) / 64;
    cnt = 0; s = addr;
    for (int i = 0; i < beats; i++) begin
      a = addr + AW'(i * 64);
      if (cnt > 0 && (cnt == 16 || a[11:0] == 12'h000)) begin
        exp_ar.push_back('{addr: s, len: 8'(cnt - 1)});
        cnt = 0;
      end
      if (cnt == 0) s = a;
      cnt++;
      t.data = mkdata(a);
      t.last = (i == beats - 1);
      t.keep = '1;
      if (t.last) begin
        nb = len - (beats - 1) * 64;
        t.keep = '0;
        for (int b = 0; b < nb; b++) t.keep[b] = 1'b1;
      end
      exp_bt.push_back(t);
    end
    if (cnt > 0) exp_ar.push_back('{addr: s, len: 8'(cnt - 1)});
  endtask

  task automatic issue(input logic [AW-1:0] addr, input int len, input bit stall_i,
                       input bit err_en_i, input logic [AW-1:0] err_a, input bit exp_err,
                       output bit ok);
    stall = stall_i; err_en = err_en_i; err_addr_g = err_a; exp_err_g = exp_err;
    len0_g = (len == 0); cmd_addr_g = addr; ar_seen = 0; beats_seen = 0;
    cmd_valid = 1; cmd_addr = addr; cmd_len = LW'(len);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("command accepted", DW'(ok), DW'(1));
  endtask

  task automatic run_cmd(input logic [AW-1:0] addr, input int len, input bit stall_i,
                         input bit err_en_i, input logic [AW-1:0] err_a, input bit exp_err,
                         input int n_ars, input int n_beats,
                         input logic [7:0] first_arlen, input logic [KW-1:0] last_keep);
    int start;
    bit ok;
    @(posedge clk); #1;
    build_model(addr, len);
    if (n_beats > 0) begin
      chk("model first arlen", DW'(exp_ar[0].len), DW'(first_arlen));
      chk("model last keep", DW'(exp_bt[exp_bt.size() - 1].keep), DW'(last_keep));
    end
    start = done_cnt;
    issue(addr, len, stall_i, err_en_i, err_a, exp_err, ok);
    if (!ok) return;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (done_cnt != start) begin ok = 1; break; end
    end
    chk("done seen", DW'(ok), DW'(1));
    chk("AR count", DW'(ar_seen), DW'(n_ars));
    chk("beat count", DW'(beats_seen), DW'(n_beats));
    chk("AR queue drained", DW'(exp_ar.size()), DW'(0));
    chk("beat queue drained", DW'(exp_bt.size()), DW'(0));
    @(negedge clk);
    stall = 0;
  endtask

  initial begin
    bit ok;
    rst_n = 0; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("cmd_ready after reset", DW'(cmd_ready), DW'(1));

    run_cmd(34'h0,    64,   0, 0, '0, 0, 1, 1,  8'd0,  64'hFFFF_FFFF_FFFF_FFFF);
    run_cmd(34'h1000, 100,  0, 0, '0, 0, 1, 2,  8'd1,  64'h0000_000F_FFFF_FFFF);
    run_cmd(34'hFC0,  256,  0, 0, '0, 0, 2, 4,  8'd0,  64'hFFFF_FFFF_FFFF_FFFF);
    run_cmd(34'h0,    2048, 1, 0, '0, 0, 2, 32, 8'd15, 64'hFFFF_FFFF_FFFF_FFFF);
    run_cmd(34'h2000, 192,  0, 1, 34'h2040, 1, 1, 3, 8'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_cmd(34'h3000, 128,  0, 0, '0, 0, 1, 2,  8'd1,  64'hFFFF_FFFF_FFFF_FFFF);
    run_cmd(34'h5000, 0,    0, 0, '0, 0, 0, 0,  8'd0,  64'h0);
    run_cmd(34'h7F00, 300,  1, 0, '0, 0, 2, 5,  8'd3,  64'h0000_0FFF_FFFF_FFFF);

    // Reset in the middle of a long stalled transfer.
    @(posedge clk); #1;
    build_model(34'h0, 2048);
    issue(34'h0, 2048, 1, 0, '0, 0, ok);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (beats_seen >= 5) begin ok = 1; break; end
    end
    chk("mid-transfer progress", DW'(ok), DW'(1));
    #1;
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid reset");
    stall = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    run_cmd(34'h100, 64, 0, 0, '0, 0, 1, 1, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
